// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Main control FSM for a multi-cycle RV32I core. Sequences each
//               instruction through IF/ID/EX/MEM/WB, drives the datapath
//               strobes and mux selects, handshakes with variable-latency
//               memory via mem_ready and counts retired instructions.
//               Optional macro ECALL_HALT_EN: ECALL with halt_cond=1 halts
//               the core (sticky is_halted) instead of acting as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             bcond,
    input  logic             halt_cond,
    output logic             pc_write,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ALU_op_sig,
    output logic             is_halted,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

    // Next-state and output decode from current state, opcode and handshakes
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        pc_source    = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        ALU_op_sig   = 1'b0;
        case (r_state)
            S_IF: begin
                // PC+4 is computed here; PC and IR commit on the same cycle
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next_state = S_ID;
            end
            S_ID: begin
                // Speculative branch target old_pc+imm lands in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BR, OP_JAL, OP_JALR: w_next_state = S_EX;
`ifdef ECALL_HALT_EN
                    OP_ECALL: w_next_state = halt_cond ? S_HALT : S_IF;
`endif
                    default:  w_next_state = S_IF;
                endcase
            end
            S_EX: begin
                w_next_state = S_IF;
                case (opcode)
                    OP_R: begin
                        alu_src_a    = 2'b10;
                        ALU_op_sig   = 1'b1;
                        w_next_state = S_WB;
                    end
                    OP_I: begin
                        alu_src_a    = 2'b10;
                        alu_src_b    = 2'b10;
                        ALU_op_sig   = 1'b1;
                        w_next_state = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a    = 2'b10;
                        alu_src_b    = 2'b10;
                        ALU_op_sig   = 1'b1;
                        w_next_state = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a  = 2'b10;
                        ALU_op_sig = 1'b1;
                        pc_write   = bcond;
                        pc_source  = 1'b1;
                    end
                    OP_JAL, OP_JALR: begin
                        // Link (old PC+4) is written while the ALU forms the target
                        alu_src_a = (opcode == OP_JALR) ? 2'b10 : 2'b01;
                        alu_src_b = 2'b10;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (mem_ready)
                    w_next_state = (opcode == OP_LOAD) ? S_WB : S_IF;
            end
            S_WB: begin
                reg_write    = 1'b1;
                wb_sel       = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                w_next_state = S_IF;
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IF;
        endcase
        // Strobes must not leak while reset is held, even though IF asserts them
        if (!reset_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // An instruction retires whenever a datapath state hands back to IF
    assign w_retire = (w_next_state == S_IF) &&
                      (r_state inside {S_ID, S_EX, S_MEM, S_WB});

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IF;
        else          r_state <= w_next_state;
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_count <= '0;
        else if (w_retire) r_count <= r_count + CNT_W'(1);
    end

    assign instr_retired = r_count;

`ifdef ECALL_HALT_EN
    logic r_halted;

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    r_halted <= 1'b0;
        else if (w_next_state == S_HALT) r_halted <= 1'b1;
    end

    assign is_halted = r_halted;
`else
    logic w_unused_halt_cond;
    assign w_unused_halt_cond = halt_cond;
    assign is_halted          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench for multicycle_control_fsm. Each scenario
//               queues per-cycle stimulus with the expected outputs and count,
//               then drains the queue cycle by cycle against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int TB_CNT_W = 3;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_UNK   = 7'b0000000;

    typedef struct packed {
        logic [6:0]          opc;
        logic                mr;
        logic                bc;
        logic                hc;
        logic [14:0]         outs;
        logic [TB_CNT_W-1:0] cnt;
    } ent_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [6:0]          opcode;
    logic                mem_ready, bcond, halt_cond;
    logic                pc_write, pc_source, i_or_d, mem_read, mem_write;
    logic                ir_write, reg_write, ALU_op_sig, is_halted;
    logic [1:0]          wb_sel, alu_src_a, alu_src_b;
    logic [TB_CNT_W-1:0] instr_retired;
    logic [14:0]         act;

    ent_t                q[$];
    ent_t                e;
    logic [TB_CNT_W-1:0] exp_cnt;
    int                  n_tests = 0;
    int                  n_fail  = 0;

    multicycle_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .bcond(bcond), .halt_cond(halt_cond), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ALU_op_sig(ALU_op_sig), .is_halted(is_halted),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    assign act = {is_halted, pc_write, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, ALU_op_sig};

    // Packs an expected output vector (is_halted=0) in the same order as act
    function automatic logic [14:0] o(input logic pcw, input logic pcs,
                                      input logic iord, input logic mrd,
                                      input logic mwr, input logic irw,
                                      input logic rw, input logic [1:0] wb,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic op);
        return {1'b0, pcw, pcs, iord, mrd, mwr, irw, rw, wb, sa, sb, op};
    endfunction

    function automatic logic [14:0] v_if1();  return o(1,0,0,1,0,1,0,2'b00,2'b00,2'b01,0); endfunction
    function automatic logic [14:0] v_if0();  return o(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,0); endfunction
    function automatic logic [14:0] v_rst();  return o(0,0,0,0,0,0,0,2'b00,2'b00,2'b01,0); endfunction
    function automatic logic [14:0] v_id();   return o(0,0,0,0,0,0,0,2'b00,2'b01,2'b10,0); endfunction
    function automatic logic [14:0] v_exr();  return o(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1); endfunction
    function automatic logic [14:0] v_exi();  return o(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,1); endfunction
    function automatic logic [14:0] v_wb0();  return o(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0); endfunction
    function automatic logic [14:0] v_wbl();  return o(0,0,0,0,0,0,1,2'b01,2'b00,2'b00,0); endfunction
    function automatic logic [14:0] v_meml(); return o(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0); endfunction
    function automatic logic [14:0] v_mems(); return o(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0); endfunction
    function automatic logic [14:0] v_br1();  return o(1,1,0,0,0,0,0,2'b00,2'b10,2'b00,1); endfunction
    function automatic logic [14:0] v_br0();  return o(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,1); endfunction
    function automatic logic [14:0] v_jal();  return o(1,0,0,0,0,0,1,2'b10,2'b01,2'b10,0); endfunction
    function automatic logic [14:0] v_jalr(); return o(1,0,0,0,0,0,1,2'b10,2'b10,2'b10,0); endfunction

    // Queue one cycle of stimulus with its expected outputs and count
    task automatic push(input logic [6:0] opc, input logic mr, input logic bc,
                        input logic hc, input logic [14:0] outs);
        ent_t t;
        t.opc = opc; t.mr = mr; t.bc = bc; t.hc = hc; t.outs = outs; t.cnt = exp_cnt;
        q.push_back(t);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opcode = OP_R; mem_ready = 1'b1; bcond = 1'b1; halt_cond = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            n_tests++;
            if ({act, instr_retired} !== {v_rst(), {TB_CNT_W{1'b0}}}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=0",
                         i, act, instr_retired, v_rst());
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        exp_cnt   = '0;
    endtask

    task automatic test_rtype();
        push(OP_R, 1, 0, 0, v_if1());
        push(OP_R, 1, 0, 0, v_id());
        push(OP_R, 1, 0, 0, v_exr());
        push(OP_R, 1, 0, 0, v_wb0());
        exp_cnt++;
        push(OP_R, 0, 0, 0, v_if0());
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL rtype[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
    endtask

    task automatic test_store_reset();
        push(OP_STORE, 0, 0, 0, v_if0());
        push(OP_STORE, 0, 0, 0, v_if0());
        push(OP_STORE, 1, 0, 0, v_if1());
        push(OP_STORE, 0, 0, 0, v_id());
        push(OP_STORE, 0, 0, 0, v_exi());
        push(OP_STORE, 0, 0, 0, v_mems());
        push(OP_STORE, 0, 0, 0, v_mems());
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL store[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
        // Abort the pending store asynchronously, away from any clock edge
        mem_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        n_tests++;
        if ({act, instr_retired} !== {v_rst(), {TB_CNT_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL store_abort: got outs=%b cnt=%0d, expected outs=%b cnt=0",
                     act, instr_retired, v_rst());
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        exp_cnt   = '0;
    endtask

    task automatic test_load();
        push(OP_LOAD, 1, 0, 0, v_if1());
        push(OP_LOAD, 0, 0, 0, v_id());
        push(OP_LOAD, 0, 0, 0, v_exi());
        push(OP_LOAD, 0, 0, 0, v_meml());
        push(OP_LOAD, 0, 0, 0, v_meml());
        push(OP_LOAD, 0, 0, 0, v_meml());
        push(OP_LOAD, 1, 0, 0, v_meml());
        push(OP_LOAD, 1, 0, 0, v_wbl());
        exp_cnt++;
        push(OP_LOAD, 0, 0, 0, v_if0());
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL load[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        push(OP_BR, 1, 1, 0, v_if1());
        push(OP_BR, 1, 1, 0, v_id());
        push(OP_BR, 1, 1, 0, v_br1());
        exp_cnt++;
        push(OP_BR, 1, 0, 0, v_if1());
        push(OP_BR, 1, 0, 0, v_id());
        push(OP_BR, 1, 0, 0, v_br0());
        exp_cnt++;
        push(OP_BR, 0, 0, 0, v_if0());
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL branch[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
    endtask

    task automatic test_jump_itype();
        push(OP_JAL, 1, 0, 0, v_if1());
        push(OP_JAL, 1, 0, 0, v_id());
        push(OP_JAL, 1, 0, 0, v_jal());
        exp_cnt++;
        push(OP_JALR, 1, 0, 0, v_if1());
        push(OP_JALR, 1, 0, 0, v_id());
        push(OP_JALR, 1, 0, 0, v_jalr());
        exp_cnt++;
        push(OP_I, 1, 0, 0, v_if1());
        push(OP_I, 1, 0, 0, v_id());
        push(OP_I, 1, 0, 0, v_exi());
        push(OP_I, 1, 0, 0, v_wb0());
        exp_cnt++;
        push(OP_UNK, 1, 0, 0, v_if1());
        push(OP_UNK, 1, 0, 0, v_id());
        exp_cnt++;
        push(OP_UNK, 0, 0, 0, v_if0());
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL jump[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
    endtask

    task automatic test_ecall();
        // halt_cond=0: always a NOP; count goes 7 -> 0 (3-bit wrap)
        push(OP_ECALL, 1, 0, 0, v_if1());
        push(OP_ECALL, 1, 0, 0, v_id());
        exp_cnt++;
        push(OP_ECALL, 1, 0, 1, v_if1());
        push(OP_ECALL, 1, 0, 1, v_id());
`ifdef ECALL_HALT_EN
        for (int i = 0; i < 3; i++) push(OP_R, 1, 1, 1, 15'h4000);
`else
        exp_cnt++;
        push(OP_ECALL, 0, 0, 1, v_if0());
`endif
        for (int s = 0; q.size() > 0; s++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.opc; mem_ready = e.mr; bcond = e.bc; halt_cond = e.hc;
            #2;
            n_tests++;
            if ({act, instr_retired} !== {e.outs, e.cnt}) begin
                n_fail++;
                $display("FAIL ecall[%0d]: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         s, act, instr_retired, e.outs, e.cnt);
            end
        end
        // Reset must clear the halt flag and return to IF
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        n_tests++;
        if ({act, instr_retired} !== {v_rst(), {TB_CNT_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL ecall_reset: got outs=%b cnt=%0d, expected outs=%b cnt=0",
                     act, instr_retired, v_rst());
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_rtype();
        test_store_reset();
        test_load();
        test_branch();
        test_jump_itype();
        test_ecall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multi-cycle RV32I CPU. It sits directly upstream of ALUControlUnit and drives its ALU_op_sig input. It sequences each instruction through IF/ID/EX/MEM/WB and generates datapath strobes: PC, IR, register file, memory, mux selects. It handshakes with a variable-latency memory through mem_ready.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0] (valid from ID onward)
mem_ready  input  1  memory access completes this cycle
bcond  input  1  ALU branch-condition flag (combinational, EX)
halt_cond  input  1  datapath: x17==10 (used only with feature)
pc_write  output  1  PC write enable
pc_source  output  1  0=ALU result, 1=ALUOut
i_or_d  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR and old_pc latch enable
reg_write  output  1  register file write enable
wb_sel  output  2  rd data: 00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  2  00=PC, 01=old_pc, 10=A(rs1)
alu_src_b  output  2  00=B(rs2), 01=const 4, 10=imm
ALU_op_sig  output  1  0=force ADD, 1=decode instruction
is_halted  output  1  sticky halt flag
instr_retired  output  CNT_W  retired instruction count

Behaviour:
- State register is 3 bits: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to IF.
- Outputs are combinational from state, opcode, mem_ready and bcond. Any signal not listed for a state is 0.
- Opcode classes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BR=1100011, JAL=1101111, JALR=1100111, ECALL=1110011.
- IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, ALU_op_sig=0.
  - ir_write=pc_write=mem_ready; pc_source=0.
  - Stay in IF until mem_ready, then go to ID.
- ID:
  - Outputs: alu_src_a=01, alu_src_b=10, ALU_op_sig=0. ALUOut captures old_pc+imm.
  - ECALL: go to IF.
  - Unknown opcode: go to IF (NOP, counted as retired).
  - All other classes: go to EX.
- EX, by opcode:
  - R: alu_src_a=10, alu_src_b=00, ALU_op_sig=1; go to WB.
  - I: alu_src_a=10, alu_src_b=10, ALU_op_sig=1; go to WB.
  - LOAD/STORE: alu_src_a=10, alu_src_b=10, ALU_op_sig=1; go to MEM.
  - BR: alu_src_a=10, alu_src_b=00, ALU_op_sig=1; pc_write=bcond, pc_source=1; go to IF.
  - JAL: alu_src_a=01, alu_src_b=10, ALU_op_sig=0; reg_write=1, wb_sel=10, pc_write=1, pc_source=0; go to IF.
  - JALR: same as JAL but alu_src_a=10.
- MEM:
  - Outputs: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE. Strobes stay high until mem_ready.
  - On mem_ready: LOAD goes to WB, STORE goes to IF.
- WB:
  - Outputs: reg_write=1; wb_sel=01 for LOAD, otherwise 00.
  - Go to IF.
- HALT: all strobes 0; terminal until reset.
- instr_retired increments by 1 on every transition into IF from ID, EX, MEM or WB. It wraps modulo 2^CNT_W.
- Reset:
  - While reset_n=0: state=IF, instr_retired=0, is_halted=0.
  - pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0.
  - Reset asserted mid-access (e.g. in MEM) aborts immediately. No strobe survives into the reset cycle.
- mem_ready outside IF/MEM is ignored.

Optional Feature:
Macro ECALL_HALT_EN.
- Defined: ID with ECALL and halt_cond=1 goes to HALT and sets is_halted=1 (sticky). The instruction is not counted. ECALL with halt_cond=0 goes to IF.
- Undefined: ECALL is always a NOP (ID to IF). is_halted is tied 0 and halt_cond is unused.

Test Plan:
- R-type add, mem_ready=1 in IF: states IF,ID,EX,WB,IF. ALU_op_sig=1 in EX only. reg_write=1 in WB with wb_sel=00. instr_retired goes 0 to 1.
- LOAD with mem_ready low for 3 cycles in MEM: mem_read and i_or_d held 1 for 4 cycles. Then WB with wb_sel=01; total 8 cycles when IF mem_ready=1.
- BR with bcond=1, then BR with bcond=0: pc_write=1 with pc_source=1 in EX for the first, pc_write=0 for the second. Both return to IF after EX.
- JALR: in EX, reg_write=1, wb_sel=10, pc_write=1, pc_source=0, alu_src_a=10. The next state is IF.
- Reset_n pulsed low during MEM of a STORE: mem_write drops to 0 asynchronously, state is IF, instr_retired=0.
- ECALL_HALT_EN defined, ECALL with halt_cond=1: is_halted=1 and stays set, instr_retired frozen, no strobes. With the macro undefined, the same stimulus returns to IF and the count increments.
